// File: rtl/seg_display_decoder_pkg.sv
// seg_display_pkg
//   Constants shared by the 3-digit 7-segment driver and its receive-side
//   decoder:
//     - segment bit positions on the 8-bit active-low segment bus
//       (bit7 = a ... bit1 = g, bit0 = dp)
//     - the 16 hex glyph patterns, as seg[7:1] (a..g), active-low
//     - active-low one-hot digit enable codes
//     - seg_pattern(): nibble -> glyph lookup
package seg_display_pkg;

    // Segment bus bit positions
    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_B_BIT  = 6;
    localparam int unsigned SEG_C_BIT  = 5;
    localparam int unsigned SEG_D_BIT  = 4;
    localparam int unsigned SEG_E_BIT  = 3;
    localparam int unsigned SEG_F_BIT  = 2;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    // Glyph patterns, {a,b,c,d,e,f,g}, 0 = segment lit
    localparam logic [6:0] SEG_PAT_0 = 7'b0000001;
    localparam logic [6:0] SEG_PAT_1 = 7'b1001111;
    localparam logic [6:0] SEG_PAT_2 = 7'b0010010;
    localparam logic [6:0] SEG_PAT_3 = 7'b0000110;
    localparam logic [6:0] SEG_PAT_4 = 7'b1001100;
    localparam logic [6:0] SEG_PAT_5 = 7'b0100100;
    localparam logic [6:0] SEG_PAT_6 = 7'b0100000;
    localparam logic [6:0] SEG_PAT_7 = 7'b0001111;
    localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9 = 7'b0000100;
    localparam logic [6:0] SEG_PAT_A = 7'b0001000;
    localparam logic [6:0] SEG_PAT_B = 7'b1100000;
    localparam logic [6:0] SEG_PAT_C = 7'b0110001;
    localparam logic [6:0] SEG_PAT_D = 7'b1000010;
    localparam logic [6:0] SEG_PAT_E = 7'b0110000;
    localparam logic [6:0] SEG_PAT_F = 7'b0111000;

    // Digit enables, active-low one-hot
    typedef enum logic [2:0] {
        EN_DIG0  = 3'b110,
        EN_DIG1  = 3'b101,
        EN_DIG2  = 3'b011,
        EN_BLANK = 3'b111
    } seg_en_e;

    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0:    pat = SEG_PAT_0;
            4'h1:    pat = SEG_PAT_1;
            4'h2:    pat = SEG_PAT_2;
            4'h3:    pat = SEG_PAT_3;
            4'h4:    pat = SEG_PAT_4;
            4'h5:    pat = SEG_PAT_5;
            4'h6:    pat = SEG_PAT_6;
            4'h7:    pat = SEG_PAT_7;
            4'h8:    pat = SEG_PAT_8;
            4'h9:    pat = SEG_PAT_9;
            4'hA:    pat = SEG_PAT_A;
            4'hB:    pat = SEG_PAT_B;
            4'hC:    pat = SEG_PAT_C;
            4'hD:    pat = SEG_PAT_D;
            4'hE:    pat = SEG_PAT_E;
            default: pat = SEG_PAT_F;
        endcase
        return pat;
    endfunction

endpackage : seg_display_pkg

// File: rtl/seg_display_decoder_pattern_decode.sv
// seg_pattern_decode
//   Combinational inverse of the hex glyph table: 7-bit active-low segment
//   pattern (a..g) -> {hit, nibble}. hit = 0 for any pattern that is not one
//   of the 16 glyphs; nibble is then 0.
//
//   Ports:
//     pattern_i  in  7  segment pattern {a,b,c,d,e,f,g}, active-low
//     hit_o      out 1  pattern matches a glyph
//     nibble_o   out 4  decoded hex value (valid when hit_o = 1)
module seg_pattern_decode
    import seg_display_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    // Glyphs are unique, so at most one iteration matches.
    always_comb begin
        hit_o    = 1'b0;
        nibble_o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern_i == seg_pattern(4'(i))) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule : seg_pattern_decode

// File: rtl/seg_display_decoder.sv
// seg_display_decoder
//   Receive side of the 3-digit multiplexed 7-segment driver. Synchronizes the
//   segment and enable lines, waits for each (enable, segment) pair to be
//   stable for SETTLE_CYCLES, decodes the glyph and rebuilds the 12-bit value.
//   Flags undecodable glyphs and multi-hot enable codes (sticky to reset).
//
//   Optional build macro SEG_DISPLAY_DECODER_TIMEOUT_EN: adds an idle counter
//   that drops digits_valid and clears the seen mask after TIMEOUT_CYCLES
//   without a legal capture.
//
//   Ports:
//     clk           in  1   system clock
//     rst_n         in  1   synchronous active-low reset
//     seven_seg     in  8   segment lines, active-low, bit7 = a .. bit0 = dp
//     seven_seg_en  in  3   digit enables, active-low one-hot
//     digits        out 12  last decoded value of each digit (digit0 = [3:0])
//     digits_valid  out 1   all three digits captured since reset/timeout
//     frame_done    out 1   one-cycle pulse on digit0 -> digit1 -> digit2
//     pattern_err   out 1   sticky, undecodable glyph captured
//     enable_err    out 1   sticky, stable enable code with >1 bit low
module seg_display_decoder
    import seg_display_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seven_seg,
    input  logic [2:0]  seven_seg_en,
    output logic [11:0] digits,
    output logic        digits_valid,
    output logic        frame_done,
    output logic        pattern_err,
    output logic        enable_err
);

    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    // Input synchronizers and previous-cycle copy
    logic [7:0]  seg_s1_q, seg_s2_q, seg_prev_q;
    logic [2:0]  en_s1_q, en_s2_q, en_prev_q;

    // Settle filter
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic        captured_q, captured_d;
    logic        changed;
    logic        capture;

    // Decoder
    logic        dec_hit;
    logic [3:0]  dec_nibble;

    // Output/frame state
    logic [11:0] digits_q, digits_d;
    logic [2:0]  seen_q, seen_d;
    logic        valid_q, valid_d;
    logic        frame_q, frame_d;
    logic        perr_q, perr_d;
    logic        eerr_q, eerr_d;
    logic        legal_cap;
    logic        timeout_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s1_q   <= '1;
            seg_s2_q   <= '1;
            seg_prev_q <= '1;
            en_s1_q    <= '1;
            en_s2_q    <= '1;
            en_prev_q  <= '1;
        end else begin
            seg_s1_q   <= seven_seg;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            en_s1_q    <= seven_seg_en;
            en_s2_q    <= en_s1_q;
            en_prev_q  <= en_s2_q;
        end
    end

    assign changed = {en_s2_q, seg_s2_q} != {en_prev_q, seg_prev_q};

    // Capture is raised on the cycle the counter steps to SETTLE_CYCLES, so
    // the capture result registers on the same edge the counter saturates.
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        captured_d   = captured_q;
        capture      = 1'b0;
        if (changed) begin
            settle_cnt_d = '0;
            captured_d   = 1'b0;
        end else if (settle_cnt_q < SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q + 8'd1;
            if (settle_cnt_q == SETTLE_LAST && !captured_q) begin
                capture    = 1'b1;
                captured_d = 1'b1;
            end
        end
    end

    seg_pattern_decode u_decode (
        .pattern_i (seg_s2_q[SEG_A_BIT:SEG_G_BIT]),
        .hit_o     (dec_hit),
        .nibble_o  (dec_nibble)
    );

    always_comb begin
        logic [2:0] sel;
        logic [2:0] seen_new;

        digits_d  = digits_q;
        seen_d    = seen_q;
        valid_d   = valid_q;
        frame_d   = 1'b0;
        perr_d    = perr_q;
        eerr_d    = eerr_q;
        legal_cap = 1'b0;
        sel       = ~en_s2_q;
        seen_new  = seen_q;

        if (capture) begin
            case (en_s2_q)
                EN_BLANK: ;
                EN_DIG0, EN_DIG1, EN_DIG2: begin
                    if (dec_hit) begin
                        legal_cap = 1'b1;
                        if (sel[0]) digits_d[3:0]  = dec_nibble;
                        if (sel[1]) digits_d[7:4]  = dec_nibble;
                        if (sel[2]) digits_d[11:8] = dec_nibble;
                        seen_new = seen_q | sel;
                        if (seen_new == 3'b111) valid_d = 1'b1;
                        // An in-order frame ends on digit2; restart tracking
                        // of digits 0 and 1 for the next frame.
                        if (sel[2] && seen_q[1:0] == 2'b11) begin
                            frame_d       = 1'b1;
                            seen_new[1:0] = 2'b00;
                        end
                        seen_d = seen_new;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                default: eerr_d = 1'b1;
            endcase
        end

        // Only fires without a legal capture, so it never masks a frame.
        if (timeout_hit) begin
            valid_d = 1'b0;
            seen_d  = '0;
        end
    end

`ifdef SEG_DISPLAY_DECODER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d      = idle_q;
        timeout_hit = 1'b0;
        if (legal_cap) begin
            idle_d = '0;
        end else if (idle_q < IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_MAX) timeout_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    // No idle timer in this build; TIMEOUT_CYCLES is folded away.
    assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt_q <= '0;
            captured_q   <= 1'b0;
            digits_q     <= '0;
            seen_q       <= '0;
            valid_q      <= 1'b0;
            frame_q      <= 1'b0;
            perr_q       <= 1'b0;
            eerr_q       <= 1'b0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
            captured_q   <= captured_d;
            digits_q     <= digits_d;
            seen_q       <= seen_d;
            valid_q      <= valid_d;
            frame_q      <= frame_d;
            perr_q       <= perr_d;
            eerr_q       <= eerr_d;
        end
    end

    assign digits       = digits_q;
    assign digits_valid = valid_q;
    assign frame_done   = frame_q;
    assign pattern_err  = perr_q;
    assign enable_err   = eerr_q;

endmodule : seg_display_decoder
